transpose_sched: RTL and testbench

TRANSPOSE_SCHED -- requirements
Module: transpose_sched

---
 rtl/transpose_sched_if.sv | 37 +++
 rtl/transpose_sched.sv | 81 ++++++++
 tb/tb_transpose_sched.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/transpose_sched_if.sv
// transpose_sched_if: handshake and buffer-control bundle between the transpose scheduler and its neighbours.
// Optional macro TRANSPOSE_SCHED_PERF_EN adds the stall_cnt performance counter.
interface transpose_sched_if
`ifdef TRANSPOSE_SCHED_PERF_EN
    #(parameter int CNT_W = 14)
`endif
;
    logic start;
    logic in_valid;
    logic in_ready;
    logic out_ready;
    logic buf_clr;
    logic buf_wr_en;
    logic buf_rd_en;
    logic busy;
    logic frame_done;
    logic overrun;
`ifdef TRANSPOSE_SCHED_PERF_EN
    logic [CNT_W-1:0] stall_cnt;
`endif

    modport slave (
        input  start, in_valid, out_ready,
        output in_ready, buf_clr, buf_wr_en, buf_rd_en, busy, frame_done, overrun
`ifdef TRANSPOSE_SCHED_PERF_EN
        , output stall_cnt
`endif
    );

    modport master (
        output start, in_valid, out_ready,
        input  in_ready, buf_clr, buf_wr_en, buf_rd_en, busy, frame_done, overrun
`ifdef TRANSPOSE_SCHED_PERF_EN
        , input stall_cnt
`endif
    );
endinterface

// File: rtl/transpose_sched.sv
// transpose_sched: frame scheduler that fills a transpose buffer from the row pass and drains it to the column pass.
// Optional macro TRANSPOSE_SCHED_PERF_EN adds stall_cnt, counting DRAIN cycles blocked by out_ready.
module transpose_sched #(
    parameter int IMAGE_WIDTH  = 110,
    parameter int IMAGE_HEIGHT = 103,
    parameter int CNT_W        = 14
) (
    input logic clk,
    input logic reset,
    transpose_sched_if.slave bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CLEAR = 3'd1;
    localparam logic [2:0] FILL  = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] FLUSH = 3'd4;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(IMAGE_WIDTH * IMAGE_HEIGHT - 1);

    logic [2:0]       state;
    logic [2:0]       state_nx;
    logic [CNT_W-1:0] wr_cnt;
    logic [CNT_W-1:0] rd_cnt;
    logic             ovr;
    logic             wr;
    logic             rd;

    assign wr             = state == FILL && bus.in_valid;
    assign rd             = state == DRAIN && bus.out_ready;
    assign bus.in_ready   = state == FILL;
    assign bus.buf_wr_en  = wr;
    assign bus.buf_rd_en  = rd;
    assign bus.buf_clr    = !reset || state == CLEAR;
    assign bus.busy       = state != IDLE;
    assign bus.frame_done = state == FLUSH;
    assign bus.overrun    = ovr;

    // Next state: advance on start, after the clear, on the last write and on the last read.
    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = bus.start ? CLEAR : IDLE;
            CLEAR:   state_nx = FILL;
            FILL:    state_nx = (wr && wr_cnt == LAST) ? DRAIN : FILL;
            DRAIN:   state_nx = (rd && rd_cnt == LAST) ? FLUSH : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    // State, frame counters and the sticky overrun flag; CLEAR starts every frame from zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            wr_cnt <= '0;
            rd_cnt <= '0;
            ovr    <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == CLEAR) begin
                wr_cnt <= '0;
                rd_cnt <= '0;
                ovr    <= 1'b0;
            end else begin
                if (wr) wr_cnt <= wr_cnt + CNT_W'(1);
                if (rd) rd_cnt <= rd_cnt + CNT_W'(1);
                if ((state == DRAIN || state == FLUSH) && bus.in_valid) ovr <= 1'b1;
            end
        end
    end

`ifdef TRANSPOSE_SCHED_PERF_EN
    logic [CNT_W-1:0] stall;

    assign bus.stall_cnt = stall;

    // Saturating count of DRAIN cycles where the column pass held off.
    always_ff @(posedge clk) begin
        if (!reset || state == CLEAR) stall <= '0;
        else if (state == DRAIN && !bus.out_ready && stall != '1) stall <= stall + CNT_W'(1);
    end
`endif
endmodule

// File: tb/tb_transpose_sched.sv
// tb_transpose_sched: randomized and directed bench for transpose_sched against a count-based frame model.
// Honours TRANSPOSE_SCHED_PERF_EN to also check stall_cnt.
`timescale 1ns/1ps
module tb_transpose_sched;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int F  = W * H;
    localparam int CW = 14;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

`ifdef TRANSPOSE_SCHED_PERF_EN
    transpose_sched_if #(.CNT_W(CW)) bus();
`else
    transpose_sched_if bus();
`endif

    transpose_sched #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .CNT_W(CW)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int s_cyc = 0;

    int n_wr, n_rd, n_done, n_rdy;
    int clr_cyc, first_rdy, last_wr, first_rd, last_rd, done_cyc;

    int m_wr, m_rd, m_stall;
    bit m_act, m_clr, m_ovr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        n_wr = 0; n_rd = 0; n_done = 0; n_rdy = 0;
        clr_cyc = -1; first_rdy = -1; last_wr = -1; first_rd = -1; last_rd = -1; done_cyc = -1;
    endtask

    // Model advances on each edge from the inputs seen there; outputs are compared mid-cycle.
    initial begin
        m_act = 0; m_clr = 0; m_ovr = 0; m_wr = 0; m_rd = 0; m_stall = 0;
        forever begin
            bit fill, drain, flush;
            @(posedge clk);
            cyc++;
            if (!reset) begin
                m_act = 0; m_clr = 0; m_wr = 0; m_rd = 0; m_ovr = 0; m_stall = 0;
            end else if (m_clr) begin
                m_clr = 0; m_wr = 0; m_rd = 0; m_ovr = 0; m_stall = 0;
            end else if (!m_act) begin
                if (bus.start) begin m_act = 1; m_clr = 1; end
            end else begin
                if (m_wr == F && bus.in_valid) m_ovr = 1;
                if (m_rd == F) m_act = 0;
                else if (m_wr < F) begin if (bus.in_valid) m_wr++; end
                else if (bus.out_ready) m_rd++;
                else if (m_stall < (1 << CW) - 1) m_stall++;
            end
            @(negedge clk);
            if (!reset) check("clr_in_reset", bus.buf_clr, 1);
            else begin
                fill  = m_act && !m_clr && m_wr < F;
                drain = m_act && !m_clr && m_wr == F && m_rd < F;
                flush = m_act && !m_clr && m_rd == F;
                check("buf_clr", bus.buf_clr, m_clr);
                check("busy", bus.busy, m_act);
                check("in_ready", bus.in_ready, fill);
                check("buf_wr_en", bus.buf_wr_en, fill && bus.in_valid);
                check("buf_rd_en", bus.buf_rd_en, drain && bus.out_ready);
                check("frame_done", bus.frame_done, flush);
                check("overrun", bus.overrun, m_ovr);
`ifdef TRANSPOSE_SCHED_PERF_EN
                check("stall_cnt", bus.stall_cnt, m_stall);
`endif
                if (bus.buf_clr && clr_cyc < 0) clr_cyc = cyc;
                if (bus.in_ready) begin n_rdy++; if (first_rdy < 0) first_rdy = cyc; end
                if (bus.buf_wr_en) begin n_wr++; last_wr = cyc; end
                if (bus.buf_rd_en) begin n_rd++; last_rd = cyc; if (first_rd < 0) first_rd = cyc; end
                if (bus.frame_done) begin n_done++; done_cyc = cyc; end
            end
        end
    end

    task automatic run_frame(input int v_last, input bit toggle, input int st_lo, input int st_hi, input int restart_at);
        int d;
        clear_stats();
        s_cyc = cyc;
        bus.start = 1; bus.in_valid = 0; bus.out_ready = 1;
        tick();
        bus.start = 0;
        for (int k = 0; k < 100 && n_done == 0; k++) begin
            d = cyc - s_cyc;
            bus.in_valid  = d <= v_last && (!toggle || d[0]);
            bus.out_ready = !(d >= st_lo && d <= st_hi);
            bus.start     = d == restart_at;
            tick();
        end
        bus.in_valid = 0; bus.out_ready = 1; bus.start = 0;
        if (n_done == 0) check("done_timeout", 0, 1);
    endtask

    initial begin
        bus.start = 0; bus.in_valid = 0; bus.out_ready = 0;
        clear_stats();
        repeat (3) tick();
        check("rst_busy", bus.busy, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_buf_clr", bus.buf_clr, 1);
        check("rst_frame_done", bus.frame_done, 0);
        check("rst_overrun", bus.overrun, 0);
        reset = 1;
        repeat (2) tick();

        run_frame(13, 0, -1, -2, -1);
        check("t2_busy_after_done", bus.busy, 0);
        check("t2_clr_latency", clr_cyc - s_cyc, 1);
        check("t2_rdy_latency", first_rdy - s_cyc, 2);
        check("t2_writes", n_wr, 12);
        check("t2_reads", n_rd, 12);
        check("t2_done_after_read", done_cyc - last_rd, 1);
        check("t2_frame_len", done_cyc - s_cyc, 26);
        check("t2_done_count", n_done, 1);
        repeat (2) tick();

        run_frame(25, 1, -1, -2, -1);
        check("t3_writes", n_wr, 12);
        check("t3_fill_cycles", n_rdy, 24);
        check("t3_last_write", last_wr - s_cyc, 25);
        check("t3_drain_next", first_rd - last_wr, 1);
        check("t3_frame_len", done_cyc - s_cyc, 38);
        repeat (2) tick();

        run_frame(13, 0, 18, 22, -1);
        check("t4_reads", n_rd, 12);
        check("t4_stall_gap", last_rd - first_rd + 1 - n_rd, 5);
        check("t4_frame_len", done_cyc - s_cyc, 31);
`ifdef TRANSPOSE_SCHED_PERF_EN
        check("t4_stall_cnt", bus.stall_cnt, 5);
`endif
        repeat (2) tick();

        run_frame(1000, 0, -1, -2, -1);
        check("t5_overrun_set", bus.overrun, 1);
        check("t5_writes", n_wr, 12);
        run_frame(13, 0, -1, -2, -1);
        check("t5_overrun_cleared", bus.overrun, 0);
        repeat (2) tick();

        clear_stats();
        s_cyc = cyc;
        bus.start = 1; tick(); bus.start = 0; bus.in_valid = 1;
        for (int k = 0; k < 40 && n_wr < 7; k++) tick();
        reset = 0; bus.in_valid = 0;
        tick();
        reset = 1;
        repeat (10) tick();
        check("t6_aborted_writes", n_wr, 7);
        check("t6_no_done", n_done, 0);
        check("t6_idle", bus.busy, 0);
        run_frame(13, 0, -1, -2, -1);
        check("t6_clr_again", clr_cyc - s_cyc, 1);
        check("t6_fresh_writes", n_wr, 12);
        check("t6_done", n_done, 1);
        repeat (2) tick();

        run_frame(13, 0, -1, -2, 6);
        repeat (30) tick();
        check("t7_one_done", n_done, 1);
        check("t7_writes", n_wr, 12);
        check("t7_idle", bus.busy, 0);

        for (int i = 0; i < 3000; i++) begin
            bus.start     = $urandom_range(15) == 0;
            bus.in_valid  = $urandom_range(1) == 1;
            bus.out_ready = $urandom_range(3) != 0;
            reset         = $urandom_range(399) != 0;
            tick();
        end
        reset = 1; bus.start = 0; bus.in_valid = 0; bus.out_ready = 1;
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
